// File: rtl/acc_shadow_stack.sv
// Accumulator register with a LIFO shadow stack for hardware save/restore of ACC
// across call and interrupt paths. All outputs are registered.
module acc_shadow_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] acc_in,
   input  logic             acc_write,
   input  logic             push,
   input  logic             pop,
   input  logic             err_clear,
   output logic [WIDTH-1:0] acc_out,
   output logic [CW-1:0]    depth_count,
   output logic             empty,
   output logic             full,
   output logic             err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic [WIDTH-1:0] stack_q [DEPTH];

   logic             both_s;
   logic             push_ok_s;
   logic             pop_ok_s;
   logic             illegal_s;
   logic [AW-1:0]    wr_idx_s;
   logic [AW-1:0]    rd_idx_s;

   // Next-state decode: op legality, accumulator source, depth and sticky error
   always_comb begin
      both_s    = push & pop;
      push_ok_s = push & ~pop & ~full_q;
      pop_ok_s  = pop & ~push & ~empty_q;
      illegal_s = both_s | (push & ~pop & full_q) | (pop & ~push & empty_q);
      wr_idx_s  = AW'(cnt_q);
      rd_idx_s  = AW'(cnt_q - CW'(1));
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      err_d     = err_q;

      // A simultaneous push and pop freezes everything, including acc_write
      if (both_s) begin
         acc_d = acc_q;
      end else if (pop_ok_s) begin
         acc_d = stack_q[rd_idx_s];
      end else if (acc_write) begin
         acc_d = acc_in;
      end else begin
         acc_d = acc_q;
      end

      if (push_ok_s) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop_ok_s) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         cnt_d = cnt_q;
      end

      if (illegal_s) begin
         err_d = 1'b1;
      end else if (err_clear) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end

      empty_d = (cnt_d == CW'(0));
      full_d  = (cnt_d == CW'(DEPTH));
   end

   // Control/status registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q   <= {WIDTH{1'b0}};
         cnt_q   <= {CW{1'b0}};
         err_q   <= 1'b0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         empty_q <= empty_d;
         full_q  <= full_d;
      end
   end

   // Stack storage is not reset; entries above depth_count are never observed
   always_ff @(posedge clk) begin
      if (!reset && push_ok_s) begin
         stack_q[wr_idx_s] <= acc_q;
      end
   end

   assign acc_out     = acc_q;
   assign depth_count = cnt_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign err         = err_q;

endmodule

// File: doc/acc_shadow_stack.md
Name: acc_shadow_stack

Overview:
Parametrised accumulator register with an attached LIFO shadow stack.
- Holds the processor accumulator (load on write enable, as in the current accumulator) and adds push/pop of the accumulator value so call/interrupt paths can save and restore ACC in hardware.
- Sits between the ALU/memory result mux and the ALU A-input; driven by the control unit.

Parameters:
WIDTH, 16, accumulator and stack entry width in bits (>=1)
DEPTH, 8, number of stack entries (>=2)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  reset reset, synchronous, active-high; clock clk
acc_in  input  WIDTH  value loaded into accumulator when acc_write=1
acc_write  input  1  load acc_in into accumulator
push  input  1  save current accumulator onto stack
pop  input  1  restore top of stack into accumulator
err_clear  input  1  clear sticky error flag
acc_out  output  WIDTH  current accumulator value (registered)
depth_count  output  CW  entries in use, 0..DEPTH; CW = clog2(DEPTH+1)
empty  output  1  depth_count==0
full  output  1  depth_count==DEPTH
err  output  1  sticky: illegal push/pop attempted

Behaviour:
- Reset (sync, priority over all inputs): acc_out=0, depth_count=0, empty=1, full=0, err=0. Stack storage is not cleared; contents after reset are don't-care and unobservable.
- All outputs are registered. Effects appear the cycle after the qualifying edge.
- empty/full are decoded from the registered depth_count and are valid in the same cycle as depth_count.
- No op (push=pop=acc_write=0): all state holds.
- acc_write only: acc_out <= acc_in.
- Valid push (push=1, pop=0, !full): stack[depth_count] <= acc_out (pre-edge value); depth_count+1.
  - With acc_write=1 in the same cycle: acc_out <= acc_in, and the old value is pushed (save-and-load in one cycle).
- Valid pop (pop=1, push=0, !empty): acc_out <= stack[depth_count-1]; depth_count-1.
  - Pop overrides acc_write; acc_in is ignored that cycle.
- Push when full:
  - No stack or depth_count change; err <= 1.
  - acc_write is still honoured.
- Pop when empty:
  - No stack, depth_count or acc change from the pop; err <= 1.
  - acc_write is still honoured.
- push=1 and pop=1 together:
  - Illegal; stack, depth_count and acc_out all hold (acc_write ignored).
  - err <= 1.
- err_clear=1: err <= 0, unless an error condition occurs in the same cycle. Set wins and err stays 1.
- Arithmetic: depth_count never wraps. It saturates logically because overflow/underflow ops are suppressed.
- Stack reads use only the pre-edge depth_count. There is no read-during-write hazard because push and pop are mutually exclusive.
- Reset asserted mid-sequence (e.g. during a push cycle): reset wins; the push is discarded and depth_count=0 next cycle.

Test Plan:
1. Reset, then acc_write with acc_in=16'h1234 -> next cycle acc_out=1234, depth_count=0, empty=1, err=0.
2. Load 0x0001, push; load 0x0002, push; load 0x0003; pop; pop -> acc_out sequence 0002 then 0001, depth_count 2->1->0, empty=1, err=0.
3. DEPTH=8: push 8 distinct values (0x0A00+i), full=1; 9th push -> depth_count stays 8, err=1. Then 8 pops -> LIFO order 0A07..0A00, empty=1.
4. Pop when empty with acc_write=1 and acc_in=0xBEEF -> acc_out=BEEF, depth_count=0, err=1. Then err_clear alone -> err=0. Then err_clear with push&pop together -> err=1, acc_out unchanged.
5. acc_out=0x5555, push+acc_write with acc_in=0xAAAA -> acc_out=AAAA, depth_count=1. Then pop+acc_write with acc_in=0x1111 -> acc_out=5555.
6. Push 3 values, assert reset with push=1 -> depth_count=0, acc_out=0, empty=1, err=0. A following pop -> err=1, acc_out=0.
